// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner select: round-robin against the last granted port, or fixed
// priority to the fetch port when PRIO_FIXED is nonzero.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_any,
  output logic       o_winner
);

  always_comb begin
    o_any    = |i_req;
    o_winner = PORT_FETCH;
    if (i_req == 2'b11) begin
      o_winner = (PRIO_FIXED != 0) ? PORT_FETCH : ~i_last;
    end else if (i_req[1]) begin
      o_winner = PORT_LS;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (port 0) and load/store
// (port 1). Optional perf counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int READ_LAT   = 1,
  parameter int PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_gnt0,
  output logic [31:0]       perf_gnt1,
  output logic [31:0]       perf_conflict,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT - 1);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  logic [CNT_W-1:0]  r_latCnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic              r_owner;
  logic              r_last;
  logic              r_rvPend;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_any;
  logic w_winner;
  logic w_done;
  logic w_grant;
  logic w_winWe;
  logic w_readGrant;
  logic w_rvalid;

  rr_arbiter2 #(
    .PRIO_FIXED(PRIO_FIXED)
  ) u_arb (
    .i_req   ({p1_req, p0_req}),
    .i_last  (r_last),
    .o_any   (w_any),
    .o_winner(w_winner)
  );

  // The last BUSY cycle (count at zero) is the rvalid cycle and also admits a new grant.
  assign w_done      = (r_state == ARB_BUSY) && (r_latCnt == '0);
  assign w_grant     = reset && w_any && ((r_state == ARB_IDLE) || w_done);
  assign w_winWe     = w_winner ? p1_we : p0_we;
  assign w_readGrant = w_grant && !w_winWe;
  assign w_rvalid    = (READ_LAT == 1) ? r_rvPend : w_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ARB_IDLE;
      r_latCnt <= '0;
      r_owner  <= PORT_FETCH;
      r_last   <= PORT_LS;
      r_rvPend <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state  <= w_nextState;
      r_latCnt <= w_nextCnt;
      r_rvPend <= (READ_LAT == 1) ? w_readGrant : 1'b0;
      if (w_readGrant) begin
        r_owner <= w_winner;
      end
      if (w_grant) begin
        r_last <= w_winner;
      end
      if (w_rvalid && !r_owner) begin
        r_rdata0 <= mem_rd;
      end
      if (w_rvalid && r_owner) begin
        r_rdata1 <= mem_rd;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_latCnt;
    case (r_state)
      ARB_IDLE: begin
        if (w_readGrant && (READ_LAT > 1)) begin
          w_nextState = ARB_BUSY;
          w_nextCnt   = LAT_INIT;
        end
      end
      ARB_BUSY: begin
        if (r_latCnt != '0) begin
          w_nextCnt = r_latCnt - CNT_W'(1);
        end else if (w_readGrant && (READ_LAT > 1)) begin
          w_nextCnt = LAT_INIT;
        end else begin
          w_nextState = ARB_IDLE;
        end
      end
      default: begin
        w_nextState = ARB_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // The memory bus idles at zero whenever no grant is issued.
  always_comb begin
    p0_gnt    = w_grant && (w_winner == PORT_FETCH);
    p1_gnt    = w_grant && (w_winner == PORT_LS);
    p0_rvalid = w_rvalid && (r_owner == PORT_FETCH);
    p1_rvalid = w_rvalid && (r_owner == PORT_LS);
    p0_rdata  = p0_rvalid ? mem_rd : r_rdata0;
    p1_rdata  = p1_rvalid ? mem_rd : r_rdata1;
    mem_we    = w_grant && w_winWe;
    mem_addr  = '0;
    mem_wd    = '0;
    if (w_grant) begin
      mem_addr = w_winner ? p1_addr : p0_addr;
      mem_wd   = w_winner ? p1_wdata : p0_wdata;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perfGnt0;
  logic [31:0] r_perfGnt1;
  logic [31:0] r_perfConflict;
  logic        w_conflict;

  assign w_conflict = ((r_state == ARB_IDLE) && p0_req && p1_req) ||
                      ((r_state == ARB_BUSY) && (p0_req || p1_req));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perfGnt0     <= '0;
      r_perfGnt1     <= '0;
      r_perfConflict <= '0;
    end else begin
      if (p0_gnt && (r_perfGnt0 != '1)) begin
        r_perfGnt0 <= r_perfGnt0 + 32'd1;
      end
      if (p1_gnt && (r_perfGnt1 != '1)) begin
        r_perfGnt1 <= r_perfGnt1 + 32'd1;
      end
      if (w_conflict && (r_perfConflict != '1)) begin
        r_perfConflict <= r_perfConflict + 32'd1;
      end
    end
  end

  assign perf_gnt0     = r_perfGnt0;
  assign perf_gnt1     = r_perfGnt1;
  assign perf_conflict = r_perfConflict;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin READ_LAT=1 instance driven from a vector
// table, plus fixed-priority and READ_LAT=3 instances exercised with hand-written sequences.
module tb_mem_arbiter;

  typedef struct packed {
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [15:0] wd0;
    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [15:0] wd1;
  } inVec_t;

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        rv0;
    logic        rv1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWd;
  } outVec_t;

  typedef struct {
    inVec_t  stim;
    outVec_t want;
  } vec_t;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  inVec_t  inA, inB, inC;
  outVec_t outA, outB, outC;
  logic [15:0] rdA, rdB, rdC;
  logic        bdWe;
  logic [15:0] bdAddr;
  logic [15:0] bdData;
  int total = 0;
  int bad = 0;
  vec_t tbl[$];

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfA0, perfA1, perfAc;
  logic [31:0] perfB0, perfB1, perfBc;
  logic [31:0] perfC0, perfC1, perfCc;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1), .PRIO_FIXED(0)) dutA (
    .clk(clk), .reset(rstA),
    .p0_req(inA.req0), .p0_we(inA.we0), .p0_addr(inA.addr0), .p0_wdata(inA.wd0),
    .p0_gnt(outA.gnt0), .p0_rvalid(outA.rv0), .p0_rdata(outA.rdata0),
    .p1_req(inA.req1), .p1_we(inA.we1), .p1_addr(inA.addr1), .p1_wdata(inA.wd1),
    .p1_gnt(outA.gnt1), .p1_rvalid(outA.rv1), .p1_rdata(outA.rdata1),
`ifdef MEM_ARB_PERF_EN
    .perf_gnt0(perfA0), .perf_gnt1(perfA1), .perf_conflict(perfAc),
`endif
    .mem_addr(outA.memAddr), .mem_we(outA.memWe), .mem_wd(outA.memWd), .mem_rd(rdA)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3), .PRIO_FIXED(0)) dutB (
    .clk(clk), .reset(rstB),
    .p0_req(inB.req0), .p0_we(inB.we0), .p0_addr(inB.addr0), .p0_wdata(inB.wd0),
    .p0_gnt(outB.gnt0), .p0_rvalid(outB.rv0), .p0_rdata(outB.rdata0),
    .p1_req(inB.req1), .p1_we(inB.we1), .p1_addr(inB.addr1), .p1_wdata(inB.wd1),
    .p1_gnt(outB.gnt1), .p1_rvalid(outB.rv1), .p1_rdata(outB.rdata1),
`ifdef MEM_ARB_PERF_EN
    .perf_gnt0(perfB0), .perf_gnt1(perfB1), .perf_conflict(perfBc),
`endif
    .mem_addr(outB.memAddr), .mem_we(outB.memWe), .mem_wd(outB.memWd), .mem_rd(rdB)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1), .PRIO_FIXED(1)) dutC (
    .clk(clk), .reset(rstA),
    .p0_req(inC.req0), .p0_we(inC.we0), .p0_addr(inC.addr0), .p0_wdata(inC.wd0),
    .p0_gnt(outC.gnt0), .p0_rvalid(outC.rv0), .p0_rdata(outC.rdata0),
    .p1_req(inC.req1), .p1_we(inC.we1), .p1_addr(inC.addr1), .p1_wdata(inC.wd1),
    .p1_gnt(outC.gnt1), .p1_rvalid(outC.rv1), .p1_rdata(outC.rdata1),
`ifdef MEM_ARB_PERF_EN
    .perf_gnt0(perfC0), .perf_gnt1(perfC1), .perf_conflict(perfCc),
`endif
    .mem_addr(outC.memAddr), .mem_we(outC.memWe), .mem_wd(outC.memWd), .mem_rd(rdC)
  );

  // Memory models: one-cycle read for A and C, three-cycle address pipe for B.
  logic [15:0] memA [0:65535];
  logic [15:0] memB [0:65535];
  logic [15:0] memC [0:65535];
  logic [15:0] rdAddrA, rdAddrC;
  logic [15:0] pipeB [3];

  always @(posedge clk) begin
    if (bdWe) memA[bdAddr] <= bdData;
    else if (outA.memWe) memA[outA.memAddr] <= outA.memWd;
    rdAddrA <= outA.memAddr;
  end

  always @(posedge clk) begin
    if (bdWe) memC[bdAddr] <= bdData;
    else if (outC.memWe) memC[outC.memAddr] <= outC.memWd;
    rdAddrC <= outC.memAddr;
  end

  always @(posedge clk) begin
    if (bdWe) memB[bdAddr] <= bdData;
    else if (outB.memWe) memB[outB.memAddr] <= outB.memWd;
    pipeB[0] <= outB.memAddr;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
  end

  assign rdA = memA[rdAddrA];
  assign rdC = memC[rdAddrC];
  assign rdB = memB[pipeB[2]];

  function automatic inVec_t mkIn(logic r0, logic w0, logic [15:0] a0, logic [15:0] d0,
                                  logic r1, logic w1, logic [15:0] a1, logic [15:0] d1);
    return '{r0, w0, a0, d0, r1, w1, a1, d1};
  endfunction

  function automatic outVec_t mkOut(logic g0, logic g1, logic v0, logic v1,
                                    logic [15:0] rd0, logic [15:0] rd1,
                                    logic we, logic [15:0] addr, logic [15:0] wd);
    return '{g0, g1, v0, v1, rd0, rd1, we, addr, wd};
  endfunction

  task automatic checkOutput(input string name, input outVec_t got, input outVec_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic checkBits(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic applyStimulus(input int idx);
    @(negedge clk);
    inA = tbl[idx].stim;
    #2;
    checkOutput($sformatf("vecA[%0d]", idx), outA, tbl[idx].want);
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bdWe = 1'b1;
    bdAddr = a;
    bdData = d;
  endtask

  initial begin
    inA = '0; inB = '0; inC = '0;
    rstA = 1'b0; rstB = 1'b0;
    bdWe = 1'b0; bdAddr = '0; bdData = '0;

    // Conflict round-robin from reset, single read, write pass-through, back-to-back writes.
    tbl.push_back('{mkIn(0,0,16'h0,16'h0,0,0,16'h0,16'h0),        mkOut(0,0,0,0,16'h0,16'h0,0,16'h0,16'h0)});
    tbl.push_back('{mkIn(1,0,16'h10,16'h0,1,0,16'h20,16'h0),      mkOut(1,0,0,0,16'h0,16'h0,0,16'h10,16'h0)});
    tbl.push_back('{mkIn(1,0,16'h10,16'h0,1,0,16'h20,16'h0),      mkOut(0,1,1,0,16'hBEEF,16'h0,0,16'h20,16'h0)});
    tbl.push_back('{mkIn(1,0,16'h10,16'h0,1,0,16'h20,16'h0),      mkOut(1,0,0,1,16'hBEEF,16'h2222,0,16'h10,16'h0)});
    tbl.push_back('{mkIn(1,0,16'h10,16'h0,1,0,16'h20,16'h0),      mkOut(0,1,1,0,16'hBEEF,16'h2222,0,16'h20,16'h0)});
    tbl.push_back('{mkIn(0,0,16'h0,16'h0,0,0,16'h0,16'h0),        mkOut(0,0,0,1,16'hBEEF,16'h2222,0,16'h0,16'h0)});
    tbl.push_back('{mkIn(1,0,16'h10,16'h0,0,0,16'h0,16'h0),       mkOut(1,0,0,0,16'hBEEF,16'h2222,0,16'h10,16'h0)});
    tbl.push_back('{mkIn(0,0,16'h0,16'h0,1,1,16'h40,16'h1234),    mkOut(0,1,1,0,16'hBEEF,16'h2222,1,16'h40,16'h1234)});
    tbl.push_back('{mkIn(1,0,16'h40,16'h0,0,0,16'h0,16'h0),       mkOut(1,0,0,0,16'hBEEF,16'h2222,0,16'h40,16'h0)});
    tbl.push_back('{mkIn(0,0,16'h0,16'h0,0,0,16'h0,16'h0),        mkOut(0,0,1,0,16'h1234,16'h2222,0,16'h0,16'h0)});
    tbl.push_back('{mkIn(1,1,16'h50,16'h5555,1,1,16'h60,16'h6666), mkOut(0,1,0,0,16'h1234,16'h2222,1,16'h60,16'h6666)});
    tbl.push_back('{mkIn(1,1,16'h50,16'h5555,1,1,16'h60,16'h6666), mkOut(1,0,0,0,16'h1234,16'h2222,1,16'h50,16'h5555)});
    tbl.push_back('{mkIn(0,0,16'h0,16'h0,1,0,16'h60,16'h0),       mkOut(0,1,0,0,16'h1234,16'h2222,0,16'h60,16'h0)});
    tbl.push_back('{mkIn(0,0,16'h0,16'h0,0,0,16'h0,16'h0),        mkOut(0,0,0,1,16'h1234,16'h6666,0,16'h0,16'h0)});

    // Requests during reset must not produce grants or bus activity.
    @(negedge clk);
    inA = mkIn(1,1,16'h10,16'hAAAA,1,0,16'h20,16'h0);
    #2;
    checkOutput("reset_quiet", outA, '0);

    preload(16'h0010, 16'hBEEF);
    preload(16'h0020, 16'h2222);
    preload(16'h0030, 16'h3333);
    @(negedge clk);
    bdWe = 1'b0;
    inA = '0;
    rstA = 1'b1;
    rstB = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(i);
    end

    // Fixed priority: port 0 wins every cycle while both are held.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inC = mkIn(1,0,16'h10,16'h0,1,0,16'h20,16'h0);
      #2;
      checkBits("prio_gnt", {30'd0, outC.gnt0, outC.gnt1}, 32'd2);
      if (i > 0) checkBits("prio_rv0", {15'd0, outC.rv0, outC.rdata0}, {15'd0, 1'b1, 16'hBEEF});
    end
    @(negedge clk);
    inC = mkIn(0,0,16'h0,16'h0,1,0,16'h20,16'h0);
    #2;
    checkBits("prio_p1_alone", {30'd0, outC.gnt0, outC.gnt1}, 32'd1);
    @(negedge clk);
    inC = '0;
    #2;
    checkBits("prio_rv1", {15'd0, outC.rv1, outC.rdata1}, {15'd0, 1'b1, 16'h2222});

    // Latency stall with READ_LAT=3: p1 read at T, p0 waits until T+3.
    @(negedge clk);
    inB = mkIn(0,0,16'h0,16'h0,1,0,16'h30,16'h0);
    #2;
    checkBits("lat_gnt1", {15'd0, outB.gnt1, outB.memAddr}, {15'd0, 1'b1, 16'h0030});
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      inB = mkIn(1,0,16'h10,16'h0,0,0,16'h0,16'h0);
      #2;
      checkBits("lat_busy", {11'd0, outB.gnt0, outB.gnt1, outB.memWe, outB.rv0, outB.rv1, outB.memAddr},
                32'd0);
    end
    @(negedge clk);
    #2;
    checkBits("lat_t3", {13'd0, outB.gnt0, outB.rv1, outB.rv0, outB.rdata1},
              {13'd0, 1'b1, 1'b1, 1'b0, 16'h3333});
    checkBits("lat_t3_addr", {16'd0, outB.memAddr}, 32'h0000_0010);
    for (int i = 4; i <= 5; i++) begin
      @(negedge clk);
      inB = '0;
      #2;
      checkBits("lat_wait", {30'd0, outB.rv0, outB.rv1}, 32'd0);
    end
    @(negedge clk);
    #2;
    checkBits("lat_rv0", {15'd0, outB.rv0, outB.rdata0}, {15'd0, 1'b1, 16'hBEEF});

    // Reset mid-read: outputs clear at once, the dropped read never returns.
    @(negedge clk);
    inB = mkIn(1,0,16'h10,16'h0,0,0,16'h0,16'h0);
    #2;
    checkBits("rst_gnt0", {31'd0, outB.gnt0}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rstB = 1'b0;
      inB = mkIn(1,0,16'h10,16'h0,1,0,16'h20,16'h0);
      #2;
      checkOutput("rst_clear", outB, '0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rstB = 1'b1;
      inB = '0;
      #2;
      checkBits("rst_no_rv", {30'd0, outB.rv0, outB.rv1}, 32'd0);
    end
    @(negedge clk);
    inB = mkIn(1,0,16'h10,16'h0,1,0,16'h20,16'h0);
    #2;
    checkBits("rst_first_conflict", {30'd0, outB.gnt0, outB.gnt1}, 32'd2);
    @(negedge clk);
    inB = '0;

`ifdef MEM_ARB_PERF_EN
    #2;
    checkBits("perf_gnt0", perfA0, 32'd5);
    checkBits("perf_gnt1", perfA1, 32'd5);
    checkBits("perf_conflict", perfAc, 32'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified memory between two requesters: port 0 = instruction fetch, port 1 = control-unit load/store.
- Sits between the requesters and the memory instance in processor_top; the memory's addr/we/wd/rd pins connect only to this block.
- Req/gnt handshake per port. One access in flight at a time. Read data is returned to the issuing port with a valid pulse.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- READ_LAT, 1, cycles from memory address sample to valid mem_rd (>=1).
- PRIO_FIXED, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset; asynchronous, active-low.
- p0_req  in  1  port 0 request; held with addr/we/wdata until gnt.
- p0_we  in  1  port 0 write enable.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 grant pulse; access issued this cycle.
- p0_rvalid  out  1  port 0 read data valid pulse.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as the port 0 signals, for port 1.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data.

Behaviour:
- States: IDLE (grant allowed) and BUSY (read in flight).
- Down-counter lat_cnt runs in BUSY; owner register records which port issued the read.
- IDLE:
  - If any req is high, pick a winner and assert its gnt combinationally.
  - Drive mem_addr/mem_we/mem_wd from the winner; the memory samples them at the next edge.
  - With no grant: mem_we=0, mem_addr=0, mem_wd=0.
- Write grant: the access completes at the grant edge. Stay IDLE; a back-to-back grant is allowed next cycle. No rvalid is generated for writes.
- Read grant at cycle T:
  - If READ_LAT=1, stay IDLE.
  - Otherwise enter BUSY with lat_cnt=READ_LAT-1.
  - In all cases the owner's rvalid pulses for exactly one cycle at T+READ_LAT, with rdata = mem_rd in that cycle.
- BUSY: no grants, and mem_we is forced to 0. lat_cnt decrements each cycle; on reaching 0 at T+READ_LAT, return to IDLE. A new grant is permitted in that same cycle (concurrent with rvalid).
- Arbitration, round-robin:
  - Register last tracks the last granted port; reset value is port 1, so port 0 wins the first conflict.
  - On a conflict, the port != last wins.
  - A single requester always wins.
  - last updates only on a grant.
- Arbitration, PRIO_FIXED=1: port 0 wins every conflict; last is unused.
- The non-winning port sees gnt=0 and must hold its request; nothing is queued.
- If req drops without a grant, nothing happens.
- p*_rdata holds its last value between rvalid pulses.
- Reset (asserted in any state):
  - gnt=0, rvalid=0, rdata=0, mem_we=0, mem_addr=0, mem_wd=0, state=IDLE, lat_cnt=0, owner=0, last=1.
  - A pending read is dropped; no rvalid is issued after reset release.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_gnt0, perf_gnt1 (32 bit each): grants per port.
  - Adds perf_conflict (32 bit): cycles in which both reqs are high in IDLE, or any req is high in BUSY.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg: state encoding (ARB_IDLE, ARB_BUSY), port index constants (PORT_FETCH=0, PORT_LS=1).
- Sub-module rr_arbiter2: pure combinational 2-way winner select from req[1:0], last and PRIO_FIXED. Instantiated once.

Test Plan:
- Single read: p0 read, addr 0x0010, mem[0x10]=0xBEEF, READ_LAT=1 -> p0_gnt same cycle; p0_rvalid=1 with p0_rdata=0xBEEF next cycle; p1 signals quiet.
- Conflict round-robin: both reqs held high continuously, reads, READ_LAT=1 -> grant order p0,p1,p0,p1. With PRIO_FIXED=1 -> p0 every cycle; p1 never granted while p0 is held.
- Latency stall: READ_LAT=3, p1 read at T with p0 req high -> p1_rvalid at T+3; p0_gnt not before T+3, and asserted at T+3.
- Write pass-through: p1 write addr 0x0040, data 0x1234 -> mem_we=1 for one cycle with mem_addr=0x0040, mem_wd=0x1234; no rvalid; subsequent p0 read of 0x0040 returns 0x1234.
- Reset mid-read: READ_LAT=3, reset asserted at T+1 after a read grant -> all outputs 0 immediately; no rvalid after release; the first conflict afterwards goes to p0.
- MEM_ARB_PERF_EN: 5 p0 grants, 3 p1 grants, 2 conflict cycles -> perf_gnt0=5, perf_gnt1=3, perf_conflict=2.
